// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - 32x32 register file with writeback bypass and pending-write scoreboard
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   regwrite, rd, write_data   writeback port from the MEM/WB stage
//   rs, rt                     combinational read addresses
//   read_data1, read_data2     read values, with same-cycle writeback bypass
//   issue_valid, issue_rd      destination claim from an instruction leaving decode
//   rs_pending, rt_pending     operand still waits on an in-flight producer
module reg_file_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic        regwrite,
    input  logic [4:0]  rd,
    input  logic [31:0] write_data,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        rs_pending,
    output logic        rt_pending
);

    logic [31:0] r_regs [32];
    logic [31:0] r_pending;

    logic        w_wr_en;
    logic        w_issue_en;
    logic        w_byp_rs;
    logic        w_byp_rt;
    logic [31:0] w_pending_next;

    // r0 is hardwired: never written, never claimed
    assign w_wr_en    = regwrite && (rd != 5'd0);
    assign w_issue_en = issue_valid && (issue_rd != 5'd0);

    assign w_byp_rs = w_wr_en && (rd == rs);
    assign w_byp_rt = w_wr_en && (rd == rt);

    // Clear for the retiring write first, then set for the new claim, so a
    // same-register set and clear leaves the newer producer pending.
    always_comb begin
        w_pending_next = r_pending;
        if (w_wr_en) begin
            w_pending_next[rd] = 1'b0;
        end
        if (w_issue_en) begin
            w_pending_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[rd] <= write_data;
            end
            r_pending <= w_pending_next;
        end
    end

    assign read_data1 = (rs == 5'd0) ? 32'd0 : (w_byp_rs ? write_data : r_regs[rs]);
    assign read_data2 = (rt == 5'd0) ? 32'd0 : (w_byp_rt ? write_data : r_regs[rt]);

    // A value arriving at writeback this cycle is bypassed, so it no longer stalls
    assign rs_pending = (rs != 5'd0) && r_pending[rs] && !w_byp_rs;
    assign rt_pending = (rt != 5'd0) && r_pending[rt] && !w_byp_rt;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - self-checking bench for reg_file_wb
module tb_reg_file_wb;

    logic        clk;
    logic        rst;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rs_pending;
    logic        rt_pending;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];

    reg_file_wb dut (
        .clk         (clk),
        .rst         (rst),
        .regwrite    (regwrite),
        .rd          (rd),
        .write_data  (write_data),
        .rs          (rs),
        .rt          (rt),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs_pending  (rs_pending),
        .rt_pending  (rt_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural register contents plus a set of
    // outstanding destination claims.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (regwrite && rd == a) return write_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_pend(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (regwrite && rd == a) return 1'b0;
        return m_pend[a];
    endfunction

    // Advance one clock; the model applies the same edge using the inputs
    // currently driven, then inputs may be changed safely after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (regwrite && rd != 0) begin
                m_regs[rd] = write_data;
                m_pend[rd] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; regwrite = 0; rd = 0; write_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        for (int a = 0; a < 32; a++) begin
            rs = a[4:0];
            rt = 5'(31 - a);
            #1;
            n_checks++;
            if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_read a=%0d: got %h/%h expected 0/0", a, read_data1, read_data2);
            end
            n_checks++;
            if (rs_pending !== 1'b0 || rt_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pending a=%0d: got %b/%b expected 0/0", a, rs_pending, rt_pending);
            end
        end
    endtask

    task automatic test_write_bypass();
        idle();
        rs = 5; rt = 0;
        regwrite = 1; rd = 5; write_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (read_data1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bypass_before_edge: got %h expected deadbeef", read_data1);
        end
        tick();
        regwrite = 0;
        #1;
        n_checks++;
        if (read_data1 !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_after_edge: got %h expected deadbeef", read_data1);
        end
        // writes to r0 are discarded
        rs = 0; rt = 0;
        regwrite = 1; rd = 0; write_data = 32'h12345678;
        #1;
        n_checks++;
        if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
            n_fail++;
            $display("FAIL r0_bypass: got %h/%h expected 0/0", read_data1, read_data2);
        end
        tick();
        regwrite = 0;
        #1;
        n_checks++;
        if (read_data1 !== 32'd0) begin
            n_fail++;
            $display("FAIL r0_write: got %h expected 0", read_data1);
        end
        // rs==rt with bypass: both ports identical
        rs = 5; rt = 5;
        regwrite = 1; rd = 5; write_data = 32'hA5A5_0F0F;
        #1;
        n_checks++;
        if (read_data1 !== 32'hA5A50F0F || read_data2 !== 32'hA5A50F0F) begin
            n_fail++;
            $display("FAIL same_port_bypass: got %h/%h expected a5a50f0f", read_data1, read_data2);
        end
        tick();
        regwrite = 0;
    endtask

    task automatic test_scoreboard();
        idle();
        rs = 0; rt = 8;
        issue_valid = 1; issue_rd = 8;
        tick();
        issue_valid = 0;
        tick();
        tick();
        n_checks++;
        if (rt_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL claim_pending: got %b expected 1", rt_pending);
        end
        regwrite = 1; rd = 8; write_data = 32'h55;
        #1;
        n_checks++;
        if (rt_pending !== 1'b0 || read_data2 !== 32'h55) begin
            n_fail++;
            $display("FAIL wb_bypass_clear: got pend=%b data=%h expected 0/55", rt_pending, read_data2);
        end
        tick();
        regwrite = 0;
        #1;
        n_checks++;
        if (rt_pending !== 1'b0 || read_data2 !== 32'h55) begin
            n_fail++;
            $display("FAIL wb_retired: got pend=%b data=%h expected 0/55", rt_pending, read_data2);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        issue_valid = 1; issue_rd = 9;
        regwrite = 1; rd = 9; write_data = 32'h77;
        tick();
        idle();
        rs = 9; rt = 9;
        #1;
        n_checks++;
        if (read_data1 !== 32'h77 || rs_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL set_clear_same: got data=%h pend=%b expected 77/1", read_data1, rs_pending);
        end
        // different registers: clear r9 and claim r10 together
        issue_valid = 1; issue_rd = 10;
        regwrite = 1; rd = 9; write_data = 32'h99;
        tick();
        idle();
        rs = 9; rt = 10;
        #1;
        n_checks++;
        if (rs_pending !== 1'b0 || rt_pending !== 1'b1 || read_data1 !== 32'h99) begin
            n_fail++;
            $display("FAIL set_clear_diff: got pend=%b/%b data=%h expected 0/1 99", rs_pending, rt_pending, read_data1);
        end
        // issue alone never alters read data
        issue_valid = 1; issue_rd = 9;
        #1;
        n_checks++;
        if (read_data1 !== 32'h99) begin
            n_fail++;
            $display("FAIL issue_no_data: got %h expected 99", read_data1);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_override();
        idle();
        issue_valid = 1; issue_rd = 3;
        tick();
        issue_rd = 4;
        tick();
        idle();
        rst = 1; regwrite = 1; rd = 3; write_data = 32'hFF;
        issue_valid = 1; issue_rd = 6;
        tick();
        idle();
        rs = 3;
        #1;
        n_checks++;
        if (read_data1 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_override_data: got %h expected 0", read_data1);
        end
        for (int a = 0; a < 32; a++) begin
            rt = a[4:0];
            #1;
            n_checks++;
            if (rt_pending !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_override_pend a=%0d: got %b expected 0", a, rt_pending);
            end
        end
        // later writeback behaves normally with no pending effect
        regwrite = 1; rd = 3; write_data = 32'h1234;
        tick();
        idle();
        rs = 3;
        #1;
        n_checks++;
        if (read_data1 !== 32'h1234 || rs_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_write: got %h/%b expected 1234/0", read_data1, rs_pending);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        bit p1, p2;
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 63) == 0);
            regwrite    = $urandom_range(0, 1);
            rd          = 5'($urandom_range(0, 7));
            write_data  = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 7));
            rs          = 5'($urandom_range(0, 7));
            rt          = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom_range(0, 7));
            #1;
            e1 = exp_read(rs);
            e2 = exp_read(rt);
            p1 = exp_pend(rs);
            p2 = exp_pend(rt);
            n_checks++;
            if (read_data1 !== e1) begin
                n_fail++;
                $display("FAIL rand_rd1 c=%0d rs=%0d: got %h expected %h", c, rs, read_data1, e1);
            end
            n_checks++;
            if (read_data2 !== e2) begin
                n_fail++;
                $display("FAIL rand_rd2 c=%0d rt=%0d: got %h expected %h", c, rt, read_data2, e2);
            end
            n_checks++;
            if (rs_pending !== p1) begin
                n_fail++;
                $display("FAIL rand_rs_pend c=%0d rs=%0d: got %b expected %b", c, rs, rs_pending, p1);
            end
            n_checks++;
            if (rt_pending !== p2) begin
                n_fail++;
                $display("FAIL rand_rt_pend c=%0d rt=%0d: got %b expected %b", c, rt, rt_pending, p2);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rs = 0; rt = 0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_write_bypass();
        test_scoreboard();
        test_same_cycle();
        test_reset_override();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
